// File: rtl/sdp_fifo_ctrl.sv
// First-word-fall-through FIFO controller for a one-clock simple dual-port RAM.
// A 2-entry head/skid output stage hides the RAM's 1-cycle read latency.
module sdp_fifo_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  output logic              overflow,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [ADDR_W+1:0] level,
  output logic              ram_ena,
  output logic              ram_wea,
  output logic [ADDR_W-1:0] ram_addra,
  output logic [DATA_W-1:0] ram_dia,
  output logic              ram_enb,
  output logic [ADDR_W-1:0] ram_addrb,
  input  logic [DATA_W-1:0] ram_dob
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] wptr_r, rptr_r;
  logic [ADDR_W:0]   ram_cnt_r, ram_cnt_n;
  logic              inflight_r;
  logic              head_vld_r, skid_vld_r, head_vld_n, skid_vld_n;
  logic [DATA_W-1:0] head_r, skid_r, head_n, skid_n;
  logic              overflow_r;
  logic              wr_acc_s, rd_iss_s, pop_s;
  logic [1:0]        occ_s, occ_after_s;

  assign full       = (ram_cnt_r == DEPTH_C);
  assign overflow   = overflow_r;
  assign dout       = head_r;
  assign dout_valid = head_vld_r;
  assign level      = (ADDR_W + 2)'(ram_cnt_r) + (ADDR_W + 2)'(inflight_r) + (ADDR_W + 2)'(occ_s);

  // Write acceptance, pop and read-issue decisions; RAM port drive.
  always_comb begin
    pop_s       = head_vld_r && dout_ready;
    occ_s       = {1'b0, head_vld_r} + {1'b0, skid_vld_r};
    occ_after_s = occ_s - {1'b0, pop_s};
    wr_acc_s    = wr_en && !full && !rst;
    // Only entries registered in earlier cycles are readable, so same-address collisions never occur.
    rd_iss_s    = !rst && (ram_cnt_r != '0) && ((occ_after_s + {1'b0, inflight_r}) < 2'd2);
    ram_ena     = wr_acc_s;
    ram_wea     = wr_acc_s;
    ram_addra   = wptr_r;
    ram_dia     = din;
    ram_enb     = rd_iss_s;
    ram_addrb   = rptr_r;
  end

  // RAM occupancy next state.
  always_comb begin
    ram_cnt_n = ram_cnt_r;
    case ({wr_acc_s, rd_iss_s})
      2'b10:   ram_cnt_n = ram_cnt_r + (ADDR_W + 1)'(1);
      2'b01:   ram_cnt_n = ram_cnt_r - (ADDR_W + 1)'(1);
      default: ram_cnt_n = ram_cnt_r;
    endcase
  end

  // Output stage next state: returning read data fills head first, else the skid slot.
  always_comb begin
    head_n     = head_r;
    skid_n     = skid_r;
    head_vld_n = head_vld_r;
    skid_vld_n = skid_vld_r;
    if (pop_s) begin
      if (skid_vld_r) begin
        head_n     = skid_r;
        head_vld_n = 1'b1;
        skid_vld_n = inflight_r;
        if (inflight_r) begin
          skid_n = ram_dob;
        end else begin
          skid_n = skid_r;
        end
      end else begin
        head_vld_n = inflight_r;
        skid_vld_n = 1'b0;
        if (inflight_r) begin
          head_n = ram_dob;
        end else begin
          head_n = head_r;
        end
      end
    end else if (!head_vld_r) begin
      head_vld_n = inflight_r;
      if (inflight_r) begin
        head_n = ram_dob;
      end else begin
        head_n = head_r;
      end
    end else if (inflight_r) begin
      skid_vld_n = 1'b1;
      skid_n     = ram_dob;
    end else begin
      skid_vld_n = skid_vld_r;
    end
  end

  // State registers; reset also drops any read still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_r     <= '0;
      rptr_r     <= '0;
      ram_cnt_r  <= '0;
      inflight_r <= 1'b0;
      head_vld_r <= 1'b0;
      skid_vld_r <= 1'b0;
      head_r     <= '0;
      skid_r     <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wptr_r <= wptr_r + ADDR_W'(1);
      end else begin
        wptr_r <= wptr_r;
      end
      if (rd_iss_s) begin
        rptr_r <= rptr_r + ADDR_W'(1);
      end else begin
        rptr_r <= rptr_r;
      end
      ram_cnt_r  <= ram_cnt_n;
      inflight_r <= rd_iss_s;
      head_vld_r <= head_vld_n;
      skid_vld_r <= skid_vld_n;
      head_r     <= head_n;
      skid_r     <= skid_n;
      overflow_r <= wr_en && full;
    end
  end

endmodule

// File: tb/tb_sdp_fifo_ctrl.sv
// Bench for sdp_fifo_ctrl: behavioural RAM, queue scoreboard, directed and random stimulus.
module tb_sdp_fifo_ctrl;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              wr_en = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic              full, overflow, dout_valid;
  logic              dout_ready = 1'b0;
  logic [DATA_W-1:0] dout;
  logic [ADDR_W+1:0] level;
  logic              ram_ena, ram_wea, ram_enb;
  logic [ADDR_W-1:0] ram_addra, ram_addrb;
  logic [DATA_W-1:0] ram_dia;
  logic [DATA_W-1:0] ram_dob = '0;

  logic [DATA_W-1:0] mem [1024];
  logic [DATA_W-1:0] model_q [$];
  int n_chk = 0;
  int n_pass = 0;
  int enb_cnt = 0;
  bit last_acc = 1'b0;
  logic [DATA_W-1:0] ctr;

  sdp_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .full(full), .overflow(overflow),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .level(level),
    .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dia(ram_dia),
    .ram_enb(ram_enb), .ram_addrb(ram_addrb), .ram_dob(ram_dob)
  );

  always #5 clk = ~clk;

  // Behavioural 1024x16 simple dual-port RAM, one-cycle read latency.
  always @(posedge clk) begin
    if (ram_ena && ram_wea) mem[ram_addra] <= ram_dia;
    if (ram_enb) ram_dob <= mem[ram_addrb];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One clock with current inputs: scoreboard update before the edge, checks 1 time unit after.
  task automatic cycle();
    bit acc, pp, hold, ovf_exp;
    logic [DATA_W-1:0] held, exp_d;
    acc = wr_en && !full;
    pp = dout_valid && dout_ready;
    hold = dout_valid && !dout_ready;
    held = dout;
    ovf_exp = wr_en && full;
    if (ram_enb) enb_cnt++;
    if (pp) begin
      if (model_q.size() == 0) chk("pop_nonempty", 32'd0, 32'd1);
      else begin
        exp_d = model_q.pop_front();
        chk("dout", 32'(dout), 32'(exp_d));
      end
    end
    if (acc) model_q.push_back(din);
    last_acc = acc;
    @(posedge clk);
    #1;
    chk("level", 32'(level), 32'(model_q.size()));
    chk("overflow", 32'(overflow), 32'(ovf_exp));
    if (hold) begin
      chk("hold_valid", 32'(dout_valid), 32'd1);
      chk("hold_data", 32'(dout), 32'(held));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_q.delete();
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
  endtask

  initial begin
    #1;
    do_reset();

    // Single write, then idle: one read issue at address 0, data visible two edges later.
    dout_ready = 1'b1;
    enb_cnt = 0;
    wr_en = 1'b1; din = 16'h1234;
    chk("enb_idle", 32'(ram_enb), 32'd0);
    cycle();
    wr_en = 1'b0;
    chk("enb_issue", 32'(ram_enb), 32'd1);
    chk("addrb0", 32'(ram_addrb), 32'd0);
    cycle();
    chk("lat_dv0", 32'(dout_valid), 32'd0);
    chk("enb_empty", 32'(ram_enb), 32'd0);
    cycle();
    chk("lat_dv1", 32'(dout_valid), 32'd1);
    chk("lat_data", 32'(dout), 32'h1234);
    for (int i = 0; i < 4; i++) cycle();
    chk("enb_pulses", 32'(enb_cnt), 32'd1);

    // Burst of five with consumer ready.
    do_reset();
    dout_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; din = DATA_W'(i + 1);
      cycle();
      if (i == 1) chk("burst_dv0", 32'(dout_valid), 32'd0);
      if (i == 2) begin
        chk("burst_dv1", 32'(dout_valid), 32'd1);
        chk("burst_first", 32'(dout), 32'h0001);
      end
    end
    wr_en = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    chk("burst_empty", 32'(level), 32'd0);

    // Fill to full with the consumer stalled, then overflow.
    do_reset();
    dout_ready = 1'b0;
    for (int i = 0; i < 1026; i++) begin
      wr_en = 1'b1; din = DATA_W'(i);
      if (i == 1025) chk("not_full_yet", 32'(full), 32'd0);
      cycle();
    end
    chk("full_set", 32'(full), 32'd1);
    chk("full_level", 32'(level), 32'd1026);
    wr_en = 1'b1; din = 16'hDEAD;
    cycle();
    chk("ovf_pulse", 32'(overflow), 32'd1);
    wr_en = 1'b0;
    cycle();
    chk("ovf_clear", 32'(overflow), 32'd0);

    // Drain while writing every cycle, crossing the read-pointer wrap.
    dout_ready = 1'b1;
    ctr = 16'h0402;
    for (int i = 0; i < 1100; i++) begin
      wr_en = 1'b1; din = ctr;
      if (i == 0) chk("full_rej", 32'(full), 32'd1);
      cycle();
      if (i == 0) chk("first_rejected", 32'(last_acc), 32'd0);
      if (last_acc) ctr = ctr + 16'd1;
    end
    wr_en = 1'b0;
    for (int i = 0; i < 1040; i++) cycle();
    chk("drained", 32'(level), 32'd0);

    // Stream with ready toggling every cycle.
    ctr = 16'hA000;
    for (int i = 0; i < 40; i++) begin
      wr_en = 1'b1; din = ctr;
      dout_ready = (i % 2 == 0);
      cycle();
      if (last_acc) ctr = ctr + 16'd1;
    end

    // Random write/ready pattern.
    for (int i = 0; i < 800; i++) begin
      wr_en = 1'($urandom_range(0, 1));
      din = DATA_W'($urandom);
      dout_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    // Reset with the pipeline busy, then check the in-flight word is dropped.
    wr_en = 1'b0; dout_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; din = DATA_W'(16'hC000 + i);
      cycle();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    dout_ready = 1'b1;
    cycle();
    do_reset();
    dout_ready = 1'b0;
    cycle();
    chk("drop_valid", 32'(dout_valid), 32'd0);
    wr_en = 1'b1; din = 16'hBEEF;
    cycle();
    wr_en = 1'b0;
    cycle();
    cycle();
    chk("beef_valid", 32'(dout_valid), 32'd1);
    chk("beef_data", 32'(dout), 32'hBEEF);
    dout_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
